// File: rtl/bus1_master.sv
// bus1_master: write-and-readback initiator for the bus1 host register file.
// Runs one req/ack transfer per command and reports compare result + stats.
module bus1_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  input  logic [2:0]       cmd_sel,
  output logic [31:0]      master_data,
  output logic             master_req,
  output logic [2:0]       reg_sel,
  input  logic [31:0]      slave_data,
  input  logic             bus_ack,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_mismatch,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic          done;
  logic          err;

  // Ack takes priority over a timeout landing in the same cycle.
  always_comb begin
    done = 1'b0;
    err  = 1'b0;
    if (state == S_WAIT) begin
      if (bus_ack) begin
        done = 1'b1;
        err  = (slave_data != master_data);
      end else if (tcnt == T_LAST) begin
        done = 1'b1;
        err  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      cmd_ready    <= 1'b0;
      master_data  <= '0;
      master_req   <= 1'b0;
      reg_sel      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
      txn_count    <= '0;
      err_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            master_data <= cmd_data;
            reg_sel     <= cmd_sel;
            master_req  <= 1'b1;
            cmd_ready   <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          master_req <= 1'b0;
          tcnt       <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (bus_ack) begin
            rsp_data     <= slave_data;
            rsp_mismatch <= (slave_data != master_data);
            rsp_timeout  <= 1'b0;
          end else if (tcnt == T_LAST) begin
            rsp_data     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b1;
          end
          if (done) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
            if (txn_count != C_MAX)
              txn_count <= txn_count + C_ONE;
            if (err && (err_count != C_MAX))
              err_count <= err_count + C_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus1_master.sv
// tb_bus1_master: directed vectors for bus1_master against a small host model.
// Host: sees req at E1, writes register at E2, acks with read-back at E3.
module tb_bus1_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_sel;
  logic [31:0] master_data;
  logic        master_req;
  logic [2:0]  reg_sel;
  logic [31:0] slave_data;
  logic        bus_ack;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_mismatch;
  logic        rsp_timeout;
  logic [15:0] txn_count;
  logic [15:0] err_count;

  bus1_master #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .master_data(master_data), .master_req(master_req),
    .reg_sel(reg_sel), .slave_data(slave_data),
    .bus_ack(bus_ack), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // host model
  logic        corrupt = 1'b0;
  logic        no_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        host_ack;
  logic [31:0] regs [8];
  int          ph;

  assign bus_ack = host_ack | stray_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= 0;
      host_ack   <= 1'b0;
      slave_data <= '0;
    end else begin
      host_ack <= 1'b0;
      case (ph)
        0: if (master_req) ph <= 1;
        1: begin
          regs[reg_sel] <= master_data ^ {31'b0, corrupt};
          ph <= 2;
        end
        default: begin
          if (!no_ack) begin
            host_ack   <= 1'b1;
            slave_data <= regs[reg_sel];
          end
          ph <= 0;
        end
      endcase
    end
  end

  // req pulse-width monitor and response capture
  int req_cnt = 0;
  int req_run = 0;
  int max_run = 0;
  int cyc = 0;
  logic [31:0] rq_data [$];
  logic        rq_mis  [$];

  always @(negedge clk) begin
    if (master_req) begin
      req_cnt++;
      req_run++;
      if (req_run > max_run) max_run = req_run;
    end else begin
      req_run = 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid && rsp_ready) begin
      rq_data.push_back(rsp_data);
      rq_mis.push_back(rsp_mismatch);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  sel;
    logic        corrupt;
    logic        no_ack;
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
    logic [15:0] txn;
    logic [15:0] err;
  } vec_t;

  vec_t vecs[4];

  // Issue one command, return edges from accept to rsp_valid.
  task automatic issue(input logic [31:0] d, input logic [2:0] s,
                       output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    cmd_data  = d;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_vld_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({name, "_rdy_back"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int r0;
    int acc[8];
    logic ok;
    logic [31:0] hd;

    vecs[0] = '{"basic", 32'hDEADBEEF, 3'd3, 1'b0, 1'b0, 4,
                32'hDEADBEEF, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[1] = '{"mism", 32'h12345678, 3'd5, 1'b1, 1'b0, 4,
                32'h12345679, 1'b1, 1'b0, 16'd2, 16'd1};
    vecs[2] = '{"tmo", 32'hA5A5A5A5, 3'd1, 1'b0, 1'b1, 17,
                32'h0, 1'b0, 1'b1, 16'd3, 16'd2};
    vecs[3] = '{"after", 32'h0F0F0F0F, 3'd6, 1'b0, 1'b0, 4,
                32'h0F0F0F0F, 1'b0, 1'b0, 16'd4, 16'd2};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    cmd_sel = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_req", {31'b0, master_req}, 32'd0);
    chk("rst_vld", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mdata", master_data, 32'd0);
    chk("rst_txn", {16'b0, txn_count}, 32'd0);
    chk("rst_err", {16'b0, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_cmd_rdy", {31'b0, cmd_ready}, 32'd1);

    foreach (vecs[i]) begin
      corrupt = vecs[i].corrupt;
      no_ack  = vecs[i].no_ack;
      r0 = req_cnt;
      issue(vecs[i].data, vecs[i].sel, lat);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_req1"}, req_cnt - r0, 32'd1);
      chk({vecs[i].name, "_data"}, rsp_data, vecs[i].rdata);
      chk({vecs[i].name, "_mis"}, {31'b0, rsp_mismatch},
          {31'b0, vecs[i].mis});
      chk({vecs[i].name, "_tmo"}, {31'b0, rsp_timeout},
          {31'b0, vecs[i].tmo});
      chk({vecs[i].name, "_txn"}, {16'b0, txn_count},
          {16'b0, vecs[i].txn});
      chk({vecs[i].name, "_err"}, {16'b0, err_count},
          {16'b0, vecs[i].err});
      handshake(vecs[i].name);
    end
    corrupt = 1'b0;
    no_ack  = 1'b0;

    // back-to-back with rsp_ready tied high
    rq_data.delete();
    rq_mis.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n;
      cmd_data  = 32'(32'h11111111 * i);
      cmd_sel   = 3'(i);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      acc[i] = cyc;
    end
    cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    for (int i = 1; i < 8; i++)
      chk("b2b_spacing", acc[i] - acc[i-1], 32'd6);
    chk("b2b_count", rq_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rq_data.size()) begin
        chk("b2b_data", rq_data[i], 32'(32'h11111111 * i));
        chk("b2b_mis", {31'b0, rq_mis[i]}, 32'd0);
      end
    end
    chk("b2b_txn", {16'b0, txn_count}, 32'd12);
    chk("b2b_err", {16'b0, err_count}, 32'd2);

    // backpressure hold with a stray ack in RESP
    issue(32'hCAFEF00D, 3'd2, lat);
    chk("hold_lat", lat, 32'd4);
    hd = rsp_data;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      stray_ack = (k == 3);
      ok &= rsp_valid && !cmd_ready && (rsp_data == hd) &&
            !rsp_mismatch && !rsp_timeout;
    end
    stray_ack = 1'b0;
    chk("hold_stable", {31'b0, ok}, 32'd1);
    chk("hold_data", rsp_data, 32'hCAFEF00D);
    chk("hold_txn", {16'b0, txn_count}, 32'd13);
    chk("hold_err", {16'b0, err_count}, 32'd2);
    handshake("hold");

    // async reset while waiting for ack
    cmd_data  = 32'h76543210;
    cmd_sel   = 3'd4;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mrst_req", {31'b0, master_req}, 32'd0);
    chk("mrst_vld", {31'b0, rsp_valid}, 32'd0);
    chk("mrst_txn", {16'b0, txn_count}, 32'd0);
    chk("mrst_err", {16'b0, err_count}, 32'd0);
    chk("mrst_rdy", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h0BADF00D, 3'd7, lat);
    chk("post_lat", lat, 32'd4);
    chk("post_data", rsp_data, 32'h0BADF00D);
    chk("post_txn", {16'b0, txn_count}, 32'd1);
    handshake("post");

    chk("req_width", max_run, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
